// File: rtl/execute_cc_stage.sv
// y86 execute-stage condition codes and E/M pipeline register.
// Latches ZF/SF/OF from the ALU result, evaluates jXX/cmovXX conditions, and registers results.
module execute_cc_stage #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             e_valid,
    input  logic [3:0]       e_icode,
    input  logic [3:0]       e_ifun,
    input  logic [WIDTH-1:0] alu_y,
    input  logic             alu_of,
    input  logic             set_cc,
    input  logic             suppress_cc,
    input  logic             stall,
    input  logic             bubble,
    output logic             zf,
    output logic             sf,
    output logic             of,
    output logic             e_cnd,
    output logic             m_valid,
    output logic [3:0]       m_icode,
    output logic [WIDTH-1:0] m_valE,
    output logic             m_cnd
);

    localparam logic [3:0] ICODE_NOP = 4'h1;

    logic cc_update;
    logic lt;

    assign cc_update = e_valid & set_cc & ~suppress_cc & ~stall & ~bubble;
    assign lt        = sf ^ of;

    // Condition from the CC as it stands before this instruction's update.
    always_comb begin
        e_cnd = 1'b0;
        case (e_ifun)
            4'd0:    e_cnd = 1'b1;
            4'd1:    e_cnd = lt | zf;
            4'd2:    e_cnd = lt;
            4'd3:    e_cnd = zf;
            4'd4:    e_cnd = ~zf;
            4'd5:    e_cnd = ~lt;
            4'd6:    e_cnd = ~lt & ~zf;
            default: e_cnd = 1'b0;
        endcase
    end

    // Condition-code register.
    always_ff @(posedge clk) begin
        if (rst) begin
            zf <= 1'b1;
            sf <= 1'b0;
            of <= 1'b0;
        end else if (cc_update) begin
            zf <= (alu_y == '0);
            sf <= alu_y[WIDTH-1];
            of <= alu_of;
        end
    end

    // E/M register: reset, then bubble, then stall, else load.
    always_ff @(posedge clk) begin
        if (rst || bubble) begin
            m_valid <= 1'b0;
            m_icode <= ICODE_NOP;
            m_valE  <= '0;
            m_cnd   <= 1'b0;
        end else if (!stall) begin
            m_valid <= e_valid;
            m_icode <= e_icode;
            m_valE  <= alu_y;
            m_cnd   <= e_cnd;
        end
    end

endmodule
